// File: rtl/fir_filter_mc_if.sv
// Purpose: handshake and coefficient bundle between the FIR core and its host.
// Latency: none, this is wiring only.
// Backpressure: in_ready / out_ready on the pixel and result channels.
interface fir_filter_mc_if #(
    parameter int DW = 8,
    parameter int CH = 3,
    parameter int CW = 8
);
    logic               coef_load;
    logic [CW-1:0]      coef_data;
    logic               in_valid;
    logic [CH*DW-1:0]   in_data;
    logic               in_ready;
    logic               out_valid;
    logic [CH*DW-1:0]   out_data;
    logic               out_ready;
    logic               coef_ok;

    // Host side: loads coefficients, streams pixels, consumes results.
    modport master (
        output coef_load, coef_data, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, coef_ok
    );

    // Core side.
    modport slave (
        input  coef_load, coef_data, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, coef_ok
    );
endinterface

// File: rtl/fir_filter_mc.sv
// Purpose: multi-channel TAPS-window FIR, scale + saturate; FIR_ROUND_EN adds round-half-up before the shift.
// Latency: result valid one cycle after the last tap of a window is accepted; TAPS+1 cycles minimum between results.
// Backpressure: in_ready low while loading or holding a result; result held stable until out_ready.
module fir_filter_mc #(
    parameter int DW    = 8,
    parameter int CH    = 3,
    parameter int TAPS  = 9,
    parameter int CW    = 8,
    parameter int SHIFT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    fir_filter_mc_if.slave  fir_if
);
    localparam int TW = $clog2(TAPS);
    localparam int PW = CW + DW + 1;
    localparam int AW = CW + DW + 1 + $clog2(TAPS);

`ifdef FIR_ROUND_EN
    localparam int          RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [AW:0] RND = (SHIFT > 0) ? ({{AW{1'b0}}, 1'b1} << RSH) : '0;
`else
    localparam logic [AW:0] RND = '0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, ACC, OUT} state_t;

    state_t                 r_state, w_state_nxt;
    logic signed [CW-1:0]   r_coef [TAPS];
    logic [TW-1:0]          r_wr_idx, r_tap_idx, w_wr_ptr, w_wr_nxt;
    logic                   r_coef_ok;
    logic signed [AW-1:0]   r_acc [CH];
    logic signed [AW-1:0]   w_sum [CH];
    logic [CH*DW-1:0]       r_out_data, w_res;
    logic                   w_in_ready, w_coef_we, w_accept, w_last;
    logic signed [CW-1:0]   w_coef_cur;

    assign w_coef_cur = r_coef[r_tap_idx];
    assign w_accept   = fir_if.in_valid & w_in_ready;
    assign w_last     = w_accept && (r_tap_idx == TW'(TAPS - 1));

    // A load burst always starts at coef[0] from IDLE, then walks wr_idx with wrap.
    assign w_wr_ptr = (r_state == IDLE) ? '0 : r_wr_idx;
    assign w_wr_nxt = (w_wr_ptr == TW'(TAPS - 1)) ? '0 : w_wr_ptr + 1'b1;

    // Per channel: product, running sum, rounding, shift and saturation.
    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic signed [PW-1:0] w_mul_a, w_mul_b, w_prod;
        logic signed [AW:0]   w_rsum, w_shr;

        assign w_mul_a  = {{(DW+1){w_coef_cur[CW-1]}}, w_coef_cur};
        assign w_mul_b  = {{CW{1'b0}}, 1'b0, fir_if.in_data[c*DW +: DW]};
        assign w_prod   = w_mul_a * w_mul_b;
        assign w_sum[c] = r_acc[c] + {{(AW-PW){w_prod[PW-1]}}, w_prod};
        // One extra bit so the rounding constant can never wrap the sum.
        assign w_rsum   = {w_sum[c][AW-1], w_sum[c]} + $signed(RND);
        assign w_shr    = w_rsum >>> SHIFT;
        assign w_res[c*DW +: DW] = w_shr[AW]            ? '0 :
                                   (|w_shr[AW-1:DW])    ? {DW{1'b1}} :
                                                          w_shr[DW-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, input-ready and coefficient write enable.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_coef_we   = 1'b0;
        case (r_state)
            IDLE: begin
                if (fir_if.coef_load) begin
                    w_coef_we   = 1'b1;
                    w_state_nxt = LOAD;
                end else if (r_coef_ok) begin
                    w_in_ready = 1'b1;
                    if (fir_if.in_valid) w_state_nxt = ACC;
                end
            end
            LOAD: begin
                if (fir_if.coef_load) w_coef_we   = 1'b1;
                else                  w_state_nxt = IDLE;
            end
            ACC: begin
                w_in_ready = 1'b1;
                if (fir_if.in_valid && (r_tap_idx == TW'(TAPS - 1))) w_state_nxt = OUT;
            end
            OUT: begin
                if (fir_if.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Coefficient store; coef_ok drops on a new burst and sets on its first wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
            r_wr_idx  <= '0;
            r_coef_ok <= 1'b0;
        end else if (w_coef_we) begin
            r_coef[w_wr_ptr] <= $signed(fir_if.coef_data);
            r_wr_idx         <= w_wr_nxt;
            if (r_state == IDLE)                  r_coef_ok <= 1'b0;
            else if (w_wr_ptr == TW'(TAPS - 1))   r_coef_ok <= 1'b1;
        end
    end

    // Window accumulation; the last tap registers the result and rearms the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) r_acc[c] <= '0;
            r_tap_idx  <= '0;
            r_out_data <= '0;
        end else if (w_last) begin
            for (int c = 0; c < CH; c++) r_acc[c] <= '0;
            r_tap_idx  <= '0;
            r_out_data <= w_res;
        end else if (w_accept) begin
            for (int c = 0; c < CH; c++) r_acc[c] <= w_sum[c];
            r_tap_idx  <= r_tap_idx + 1'b1;
        end
    end

    assign fir_if.in_ready  = w_in_ready;
    assign fir_if.out_valid = (r_state == OUT);
    assign fir_if.out_data  = r_out_data;
    assign fir_if.coef_ok   = r_coef_ok;
endmodule

// File: tb/tb_fir_filter_mc.sv
// Purpose: randomized self-checking bench for fir_filter_mc, SHIFT=0 and SHIFT=4 cores on shared stimulus.
// Latency: expects out_valid the cycle after the last accepted tap.
// Backpressure: exercises out_ready stalls, input gaps and partial coefficient loads.
module tb_fir_filter_mc;
    localparam int DW   = 8;
    localparam int CH   = 3;
    localparam int TAPS = 9;
    localparam int CW   = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               coef_load = 1'b0;
    logic [CW-1:0]      coef_data = '0;
    logic               in_valid = 1'b0;
    logic [CH*DW-1:0]   in_data = '0;
    logic               out_ready = 1'b0;

    int n_err = 0;
    int n_chk = 0;

    // Reference model state: coefficient set, load status, running window sums.
    int                 coef_m [TAPS];
    bit                 ok_m;
    int                 acc_m [CH];
    int                 tap_m;
    logic [CH*DW-1:0]   last_exp0;

    always #5 clk = ~clk;

    fir_filter_mc_if #(.DW(DW), .CH(CH), .CW(CW)) u_if0 ();
    fir_filter_mc_if #(.DW(DW), .CH(CH), .CW(CW)) u_if4 ();

    assign u_if0.coef_load = coef_load;
    assign u_if0.coef_data = coef_data;
    assign u_if0.in_valid  = in_valid;
    assign u_if0.in_data   = in_data;
    assign u_if0.out_ready = out_ready;
    assign u_if4.coef_load = coef_load;
    assign u_if4.coef_data = coef_data;
    assign u_if4.in_valid  = in_valid;
    assign u_if4.in_data   = in_data;
    assign u_if4.out_ready = out_ready;

    fir_filter_mc #(.DW(DW), .CH(CH), .TAPS(TAPS), .CW(CW), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .fir_if(u_if0)
    );
    fir_filter_mc #(.DW(DW), .CH(CH), .TAPS(TAPS), .CW(CW), .SHIFT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .fir_if(u_if4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) coef_m[i] = 0;
        for (int c = 0; c < CH; c++) acc_m[c] = 0;
        ok_m  = 1'b0;
        tap_m = 0;
    endfunction

    // Scale, optionally round, and clamp each channel's window sum.
    function automatic logic [CH*DW-1:0] ref_out(input int sh);
        logic [CH*DW-1:0] r;
        int v;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            v = acc_m[c];
`ifdef FIR_ROUND_EN
            if (sh > 0) v = v + (1 << (sh - 1));
`endif
            v = v >>> sh;
            if (v < 0) v = 0;
            else if (v > (1 << DW) - 1) v = (1 << DW) - 1;
            r[c*DW +: DW] = v[DW-1:0];
        end
        return r;
    endfunction

    // Entered and left at posedge+1.
    task automatic load_coefs(input int n, input bit rnd, input logic [CW-1:0] val);
        logic [CW-1:0] v;
        int idx;
        idx  = 0;
        ok_m = 1'b0;
        for (int i = 0; i < n; i++) begin
            v = rnd ? CW'($urandom) : val;
            coef_load = 1'b1;
            coef_data = v;
            coef_m[idx] = int'($signed(v));
            idx = (idx + 1) % TAPS;
            if (idx == 0) ok_m = 1'b1;
            @(posedge clk); #1;
        end
        coef_load = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("coef_ok", 32'(u_if0.coef_ok), 32'(ok_m));
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [CH*DW-1:0] d);
        int budget;
        in_valid = 1'b1;
        in_data  = d;
        budget   = 50;
        @(negedge clk);
        while (!u_if0.in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!u_if0.in_ready) check("beat_timeout", 32'(u_if0.in_ready), 32'd1);
        check("ov_pre", 32'(u_if0.out_valid), 32'd0);
        @(posedge clk);
        for (int c = 0; c < CH; c++)
            acc_m[c] = acc_m[c] + coef_m[tap_m] * int'(d[c*DW +: DW]);
        tap_m = tap_m + 1;
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_window(input bit rnd, input logic [CH*DW-1:0] d, input bit gaps);
        for (int t = 0; t < TAPS; t++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_beat(rnd ? (CH*DW)'($urandom) : d);
        end
        @(negedge clk);
        last_exp0 = ref_out(0);
        check("ov_rise", 32'(u_if0.out_valid), 32'd1);
        check("ir_out", 32'(u_if0.in_ready), 32'd0);
        check("data_s0", 32'(u_if0.out_data), 32'(last_exp0));
        check("data_s4", 32'(u_if4.out_data), 32'(ref_out(4)));
        for (int c = 0; c < CH; c++) acc_m[c] = 0;
        tap_m = 0;
        @(posedge clk); #1;
    endtask

    task automatic take_result(input int hold, input bit poke);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                coef_load = 1'b1;
                coef_data = CW'($urandom);
            end
            @(negedge clk);
            check("ov_hold", 32'(u_if0.out_valid), 32'd1);
            check("ir_hold", 32'(u_if0.in_ready), 32'd0);
            check("data_hold", 32'(u_if0.out_data), 32'(last_exp0));
            @(posedge clk); #1;
        end
        coef_load = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("ov_fall", 32'(u_if0.out_valid), 32'd0);
        check("ir_idle", 32'(u_if0.in_ready), 32'(ok_m));
        check("data_keep", 32'(u_if0.out_data), 32'(last_exp0));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ov", 32'(u_if0.out_valid), 32'd0);
        check("rst_od", 32'(u_if0.out_data), 32'd0);
        check("rst_ok", 32'(u_if0.coef_ok), 32'd0);
        check("rst_ir", 32'(u_if0.in_ready), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;

        // Unit coefficients, ch2 saturates.
        load_coefs(9, 1'b0, 8'd1);
        run_window(1'b0, {8'd30, 8'd20, 8'd10}, 1'b0);
        take_result(0, 1'b0);

        // All -1 coefficients clamp to zero.
        load_coefs(9, 1'b0, 8'hFF);
        run_window(1'b0, {8'd5, 8'd5, 8'd5}, 1'b0);
        take_result(0, 1'b0);

        // Sum 27: scaled core shows floor vs. rounding.
        load_coefs(9, 1'b0, 8'd1);
        run_window(1'b0, {8'd3, 8'd3, 8'd3}, 1'b0);
        take_result(0, 1'b0);

        // Output stall with ignored coefficient writes, then the same set still applies.
        run_window(1'b0, {8'd30, 8'd20, 8'd10}, 1'b0);
        take_result(5, 1'b1);
        run_window(1'b0, {8'd30, 8'd20, 8'd10}, 1'b0);
        take_result(0, 1'b0);

        // Input gaps, then a partial load blocks input.
        run_window(1'b0, {8'd30, 8'd20, 8'd10}, 1'b1);
        take_result(2, 1'b0);
        load_coefs(5, 1'b1, 8'd0);
        in_valid = 1'b1;
        in_data  = {8'd1, 8'd2, 8'd3};
        @(negedge clk);
        check("ir_partial", 32'(u_if0.in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("ov_partial", 32'(u_if0.out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Random coefficients and pixels, including an overwriting over-long load.
        load_coefs(9, 1'b1, 8'd0);
        repeat (3) begin
            run_window(1'b1, '0, 1'b1);
            take_result($urandom_range(0, 2), 1'b0);
        end
        load_coefs(12, 1'b1, 8'd0);
        run_window(1'b1, '0, 1'b0);
        take_result(1, 1'b0);

        // Reset in the middle of a window.
        load_coefs(9, 1'b0, 8'd1);
        for (int t = 0; t < 4; t++) send_beat({8'd77, 8'd66, 8'd55});
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_ov", 32'(u_if0.out_valid), 32'd0);
        check("mid_rst_od", 32'(u_if0.out_data), 32'd0);
        check("mid_rst_ok", 32'(u_if0.coef_ok), 32'd0);
        check("mid_rst_ir", 32'(u_if0.in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_coefs(9, 1'b0, 8'd1);
        run_window(1'b0, {8'd30, 8'd20, 8'd10}, 1'b0);
        take_result(0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
